// File: rtl/comm_master_seq.sv
// comm_master_seq
// Host-side command sequencer for the logic-analyzer command link.
// Sends a CMD_BYTES-wide command MSB byte first through a byte UART
// transmitter, then gathers a RESP_BYTES-wide response from a byte UART
// receiver. A per-byte timeout aborts a response that stops arriving.

module comm_master_seq #(
    parameter int CMD_BYTES   = 2,
    parameter int RESP_BYTES  = 1,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*CMD_BYTES-1:0]  cmd,
    input  logic                    snd_cmd,
    output logic                    busy,
    output logic                    cmd_cmplt,
    output logic                    trmt,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    input  logic                    rx_rdy,
    input  logic [7:0]              rx_data,
    output logic                    clr_rx_rdy,
    output logic [8*RESP_BYTES-1:0] resp,
    output logic                    resp_rdy,
    input  logic                    clr_resp_rdy,
    output logic                    timeout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TX_LOAD = 2'd1;
    localparam logic [1:0] TX_WAIT = 2'd2;
    localparam logic [1:0] RX_WAIT = 2'd3;

    // One byte counter serves both the command and the response phase.
    localparam int MAX_BYTES = (CMD_BYTES > RESP_BYTES) ? CMD_BYTES : RESP_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BYTES - 1);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_BYTES - 1);

    // Timeout counter; TIMEOUT_CYC == 0 turns the timeout off entirely.
    localparam bit TMO_EN = (TIMEOUT_CYC != 0);
    localparam int TMO_W  = TMO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? TIMEOUT_CYC - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [8*CMD_BYTES-1:0]  shreg;
    logic [CNT_W-1:0]        byte_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [8*RESP_BYTES-1:0] resp_nxt;

    logic accept;
    logic tx_step;
    logic tx_last;
    logic rx_take;
    logic rx_last;
    logic tmo_hit;

    // Events that drive the FSM and datapath.
    assign accept  = (state == IDLE) && snd_cmd;
    assign tx_step = (state == TX_WAIT) && tx_done;
    assign tx_last = tx_step && (byte_cnt == CMD_LAST);
    assign rx_take = (state == RX_WAIT) && rx_rdy;
    assign rx_last = rx_take && (byte_cnt == RESP_LAST);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit = TMO_EN && (state == RX_WAIT) && !rx_rdy && (tmo_cnt == TMO_LAST);

    assign busy       = (state != IDLE);
    assign tx_data    = shreg[8*CMD_BYTES-1 -: 8];
    // Bytes are acknowledged when they are wanted (RX_WAIT) and flushed when
    // nothing is outstanding (IDLE); during transmit they are left pending.
    assign clr_rx_rdy = rx_rdy && ((state == IDLE) || (state == RX_WAIT));

    // Response shift: newest byte enters at the bottom, first byte ends on top.
    generate
        if (RESP_BYTES == 1) begin : g_resp1
            assign resp_nxt = rx_data;
        end else begin : g_respn
            assign resp_nxt = {resp[8*RESP_BYTES-9:0], rx_data};
        end
    endgenerate

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snd_cmd) state_nxt = TX_LOAD;
            TX_LOAD: state_nxt = TX_WAIT;
            TX_WAIT: if (tx_done) state_nxt = tx_last ? RX_WAIT : TX_LOAD;
            RX_WAIT: if (rx_last || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Command shift register: loaded on accept, advanced one byte per tx_done.
    always_ff @(posedge clk) begin
        if (rst)          shreg <= '0;
        else if (accept)  shreg <= cmd;
        else if (tx_step) shreg <= shreg << 8;
    end

    // trmt pulse. The first byte is launched straight from the accept so
    // trmt lines up with busy; later bytes are launched from TX_LOAD, which
    // puts them two cycles after the previous tx_done.
    always_ff @(posedge clk) begin
        if (rst) trmt <= 1'b0;
        else     trmt <= accept || ((state == TX_LOAD) && (byte_cnt != '0));
    end

    // Command-complete pulse, one cycle after the last tx_done.
    always_ff @(posedge clk) begin
        if (rst) cmd_cmplt <= 1'b0;
        else     cmd_cmplt <= tx_last;
    end

    // Byte counter: bytes sent in the TX phase, bytes taken in the RX phase.
    always_ff @(posedge clk) begin
        if (rst)          byte_cnt <= '0;
        else if (accept)  byte_cnt <= '0;
        else if (tx_step) byte_cnt <= tx_last ? '0 : byte_cnt + CNT_W'(1);
        else if (rx_take) byte_cnt <= byte_cnt + CNT_W'(1);
    end

    // Inter-byte timeout counter; restarts per response byte, saturates.
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (tx_last || rx_take)
            tmo_cnt <= '0;
        else if ((state == RX_WAIT) && (tmo_cnt != TMO_MAX))
            tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // Response assembly; a timeout leaves the partial contents in place.
    always_ff @(posedge clk) begin
        if (rst)          resp <= '0;
        else if (rx_take) resp <= resp_nxt;
    end

    // Sticky response-ready; setting beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)                          resp_rdy <= 1'b0;
        else if (rx_last)                 resp_rdy <= 1'b1;
        else if (accept || clr_resp_rdy)  resp_rdy <= 1'b0;
    end

    // Sticky timeout flag, cleared when the next command is accepted.
    always_ff @(posedge clk) begin
        if (rst)          timeout <= 1'b0;
        else if (tmo_hit) timeout <= 1'b1;
        else if (accept)  timeout <= 1'b0;
    end

endmodule
